// File: rtl/latency_stats.sv
// latency_stats: consumes a completed TX/RX timestamp pair, turns it into a
// latency sample and folds it into running statistics, then re-arms the latch.
module latency_stats #(
   parameter int DELTA_W = 32,
   parameter int SUM_W   = 48,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [63:0]        ts_tx,
   input  logic [63:0]        ts_rx,
   input  logic               ts_valid,
   output logic               ts_clear,
   input  logic               stats_clear,
   input  logic [DELTA_W-1:0] alarm_thresh,
   output logic               lat_valid,
   output logic               lat_err,
   output logic               lat_alarm,
   output logic [DELTA_W-1:0] lat_last,
   output logic [DELTA_W-1:0] lat_min,
   output logic [DELTA_W-1:0] lat_max,
   output logic [SUM_W-1:0]   lat_sum,
   output logic [CNT_W-1:0]   lat_count,
   output logic [CNT_W-1:0]   err_count
);

   localparam int SUMX_W = SUM_W + 1;

   typedef enum logic [1:0] {IDLE, UPDATE, CLEAR, HOLD} state_t;

   state_t            state;
   state_t            next_state;
   logic [63:0]       diff;
   logic              neg;
   logic [63:0]       raw_diff;
   logic              over;
   logic [DELTA_W-1:0] sample;
   logic [SUMX_W-1:0] sum_ext;

   assign raw_diff = ts_rx - ts_tx;

   // State register; reset returns to IDLE and abandons any pending sample.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic: accept a pair in IDLE, then walk UPDATE/CLEAR/HOLD once.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (ts_valid) next_state = UPDATE;
         UPDATE:  next_state = CLEAR;
         CLEAR:   next_state = HOLD;
         HOLD:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture the modular RX-TX difference and its sign when a pair is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         diff <= '0;
         neg  <= 1'b0;
      end else if (state == IDLE && ts_valid) begin
         diff <= raw_diff;
         neg  <= raw_diff[63];
      end
   end

   // Saturate the difference to the sample width and pre-compute the widened sum.
   always_comb begin
      over    = |(diff >> DELTA_W);
      sample  = over ? '1 : diff[DELTA_W-1:0];
      sum_ext = {1'b0, lat_sum} + SUMX_W'(sample);
   end

   // One-cycle pulses issued on the UPDATE edge, whether or not stats are cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_clear  <= 1'b0;
         lat_valid <= 1'b0;
         lat_err   <= 1'b0;
         lat_alarm <= 1'b0;
      end else begin
         ts_clear  <= (state == UPDATE);
         lat_valid <= (state == UPDATE) && !neg;
         lat_err   <= (state == UPDATE) && neg;
         lat_alarm <= (state == UPDATE) && !neg && (sample > alarm_thresh);
      end
   end

   // Running statistics; a clear on the UPDATE edge discards that sample.
   always_ff @(posedge clk) begin
      if (!rst_n || stats_clear) begin
         lat_last  <= '0;
         lat_min   <= '1;
         lat_max   <= '0;
         lat_sum   <= '0;
         lat_count <= '0;
         err_count <= '0;
      end else if (state == UPDATE) begin
         if (neg) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
         end else begin
            lat_last <= sample;
            if (sample < lat_min) lat_min <= sample;
            if (sample > lat_max) lat_max <= sample;
            lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            if (lat_count != '1) lat_count <= lat_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_latency_stats.sv
// tb_latency_stats: drives timestamp pairs like the upstream latch would and
// compares pulses and statistics against an arithmetic reference model.
module tb_latency_stats;

   localparam int DW = 32;
   localparam int SW = 33;
   localparam int CW = 32;
   localparam logic [63:0] SAMPLE_MAX = (64'd1 << DW) - 64'd1;
   localparam logic [63:0] SUM_MAX    = (64'd1 << SW) - 64'd1;
   localparam logic [63:0] CNT_MAX    = (64'd1 << CW) - 64'd1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [63:0]   ts_tx, ts_rx;
   logic          ts_valid;
   logic          ts_clear;
   logic          stats_clear;
   logic [DW-1:0] alarm_thresh;
   logic          lat_valid, lat_err, lat_alarm;
   logic [DW-1:0] lat_last, lat_min, lat_max;
   logic [SW-1:0] lat_sum;
   logic [CW-1:0] lat_count, err_count;

   int total = 0;
   int bad   = 0;

   logic [63:0] m_last, m_min, m_max, m_sum, m_count, m_err;

   latency_stats #(.DELTA_W(DW), .SUM_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ts_tx(ts_tx), .ts_rx(ts_rx),
      .ts_valid(ts_valid), .ts_clear(ts_clear), .stats_clear(stats_clear),
      .alarm_thresh(alarm_thresh), .lat_valid(lat_valid), .lat_err(lat_err),
      .lat_alarm(lat_alarm), .lat_last(lat_last), .lat_min(lat_min),
      .lat_max(lat_max), .lat_sum(lat_sum), .lat_count(lat_count),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic modelClear();
      m_last = 0; m_min = SAMPLE_MAX; m_max = 0; m_sum = 0; m_count = 0; m_err = 0;
   endtask

   task automatic checkStats(input string tag);
      checkOutput({tag, ".last"},  64'(lat_last),  m_last);
      checkOutput({tag, ".min"},   64'(lat_min),   m_min);
      checkOutput({tag, ".max"},   64'(lat_max),   m_max);
      checkOutput({tag, ".sum"},   64'(lat_sum),   m_sum);
      checkOutput({tag, ".count"}, 64'(lat_count), m_count);
      checkOutput({tag, ".err"},   64'(err_count), m_err);
   endtask

   // Present one pair, act as the latch (drop ts_valid on ts_clear), check everything.
   task automatic applyStimulus(input string tag, input logic [63:0] tx, input logic [63:0] rx, input bit clr);
      logic signed [64:0] delta;
      logic [63:0] s;
      bit is_err, exp_alarm;
      int seen_at, n_clear, n_valid, n_err, n_alarm;
      delta     = $signed({1'b0, rx}) - $signed({1'b0, tx});
      is_err    = delta < 0;
      s         = (delta > $signed({1'b0, SAMPLE_MAX})) ? SAMPLE_MAX : 64'(delta);
      exp_alarm = !is_err && (s > 64'(alarm_thresh));
      seen_at = -1; n_clear = 0; n_valid = 0; n_err = 0; n_alarm = 0;
      @(negedge clk);
      ts_tx = tx; ts_rx = rx; ts_valid = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         n_valid += int'(lat_valid);
         n_err   += int'(lat_err);
         n_alarm += int'(lat_alarm);
         if (cyc == 1 && clr) stats_clear = 1'b1;
         if (cyc == 2) stats_clear = 1'b0;
         if (ts_clear) begin
            n_clear++;
            if (seen_at < 0) seen_at = cyc;
            @(posedge clk);
            #1 ts_valid = 1'b0;
         end
      end
      ts_valid = 1'b0;
      stats_clear = 1'b0;
      if (clr) modelClear();
      else if (is_err) begin
         if (m_err != CNT_MAX) m_err++;
      end else begin
         m_last = s;
         if (s < m_min) m_min = s;
         if (s > m_max) m_max = s;
         m_sum = m_sum + s;
         if (m_sum > SUM_MAX) m_sum = SUM_MAX;
         if (m_count != CNT_MAX) m_count++;
      end
      checkOutput({tag, ".n_clear"}, 64'(n_clear), 64'd1);
      checkOutput({tag, ".latency"}, 64'(seen_at), 64'd2);
      checkOutput({tag, ".n_valid"}, 64'(n_valid), is_err ? 64'd0 : 64'd1);
      checkOutput({tag, ".n_err"},   64'(n_err),   is_err ? 64'd1 : 64'd0);
      checkOutput({tag, ".n_alarm"}, 64'(n_alarm), exp_alarm ? 64'd1 : 64'd0);
      checkStats(tag);
   endtask

   task automatic pulseStatsClear();
      @(negedge clk);
      stats_clear = 1'b1;
      @(negedge clk);
      stats_clear = 1'b0;
      modelClear();
   endtask

   // Main sequence: directed boundary cases, mid-update reset, then random pairs.
   initial begin
      rst_n = 1'b0; ts_tx = '0; ts_rx = '0; ts_valid = 1'b0;
      stats_clear = 1'b0; alarm_thresh = 32'd1000;
      modelClear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkStats("reset");
      checkOutput("reset.pulses", {60'd0, ts_clear, lat_valid, lat_err, lat_alarm}, 64'd0);

      applyStimulus("first", 64'd100, 64'd350, 1'b0);

      pulseStatsClear();
      checkStats("clear");
      alarm_thresh = 32'd40;
      applyStimulus("s40", 64'd1000, 64'd1040, 1'b0);
      applyStimulus("s10", 64'd2000, 64'd2010, 1'b0);
      applyStimulus("s70", 64'd3000, 64'd3070, 1'b0);
      applyStimulus("neg", 64'd500,  64'd400,  1'b0);
      applyStimulus("zero", 64'd77,  64'd77,   1'b0);

      pulseStatsClear();
      for (int i = 0; i < 3; i++) applyStimulus("sat", 64'd0, 64'd1 << 33, 1'b0);

      applyStimulus("clr_upd", 64'd100, 64'd350, 1'b1);

      applyStimulus("pre_rst", 64'd5, 64'd9, 1'b0);
      @(negedge clk);
      ts_tx = 64'd1000; ts_rx = 64'd1250; ts_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      modelClear();
      checkOutput("rst_upd.ts_clear", 64'(ts_clear), 64'd0);
      checkOutput("rst_upd.valid", 64'(lat_valid), 64'd0);
      checkStats("rst_upd");
      rst_n = 1'b1; ts_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_upd.quiet", {62'd0, ts_clear, lat_valid}, 64'd0);
      end
      applyStimulus("after_rst", 64'd10, 64'd30, 1'b0);

      for (int i = 0; i < 25; i++) begin
         logic [63:0] tx, rx;
         int mode;
         tx = {$urandom, $urandom};
         mode = $urandom_range(0, 9);
         if (mode <= 5)      rx = tx + 64'($urandom_range(0, 5000));
         else if (mode <= 7) rx = tx - 64'($urandom_range(1, 5000));
         else if (mode == 8) rx = tx + {29'd0, 3'($urandom_range(0, 7)), $urandom};
         else                rx = tx;
         alarm_thresh = 32'($urandom_range(0, 5000));
         applyStimulus("rand", tx, rx, $urandom_range(0, 9) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/latency_stats.md
# latency_stats

Consumer stage for the TX/RX first-beat timestamp latch. Waits for a completed timestamp pair, computes RX−TX latency in timer ticks, and folds it into running statistics: last, min, max, sum, count, error count and alarm. Then pulses `ts_clear` back to the latch to re-arm it for the next message. Sits between the timestamp latch and the CSR/readout logic.

## Interface
Parameters:
- `DELTA_W`, 32: width of a latency sample; larger deltas saturate.
- `SUM_W`, 48: width of the latency accumulator.
- `CNT_W`, 32: width of the sample and error counters.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `ts_tx`  in  64: TX first-beat timestamp from the latch.
- `ts_rx`  in  64: RX first-beat timestamp from the latch.
- `ts_valid`  in  1: pair complete. May stay high for many cycles until cleared.
- `ts_clear`  out  1: one-cycle re-arm pulse to the latch.
- `stats_clear`  in  1: zero all statistics.
- `alarm_thresh`  in  DELTA_W: alarm threshold in ticks.
- `lat_valid`  out  1: one-cycle pulse; a good sample was processed.
- `lat_err`  out  1: one-cycle pulse; the sample had RX earlier than TX.
- `lat_alarm`  out  1: one-cycle pulse; good sample > `alarm_thresh`.
- `lat_last`  out  DELTA_W: latest good sample.
- `lat_min`  out  DELTA_W: minimum good sample; all-ones when count is 0.
- `lat_max`  out  DELTA_W: maximum good sample.
- `lat_sum`  out  SUM_W: sum of good samples, saturating.
- `lat_count`  out  CNT_W: good-sample count, saturating.
- `err_count`  out  CNT_W: error-sample count, saturating.

## Operation
- FSM states: IDLE → UPDATE → CLEAR → HOLD → IDLE.
- IDLE, `ts_valid`=1:
  - register `diff = ts_rx − ts_tx` (64-bit, mod 2^64) and `neg = diff[63]`;
  - go to UPDATE.
- IDLE, `ts_valid`=0: stay in IDLE.
- UPDATE:
  - Sample: `sat = (diff ≥ 2^DELTA_W) ? all-ones : diff[DELTA_W-1:0]`.
  - If `neg`:
    - `err_count`++, `lat_err` pulses;
    - no other statistic changes.
  - Else:
    - `lat_last` = sample;
    - `lat_min`/`lat_max` updated by unsigned compare;
    - `lat_sum` += sample, clamped at all-ones;
    - `lat_count`++, clamped at all-ones;
    - `lat_valid` pulses;
    - `lat_alarm` pulses if sample > `alarm_thresh` (strict).
  - `ts_clear` pulses in both cases.
  - Go to CLEAR.
- CLEAR: go to HOLD.
- HOLD: go to IDLE. `ts_valid` is ignored in both CLEAR and HOLD.
- `stats_clear`:
  - zeroes `lat_last`, `lat_max`, `lat_sum`, `lat_count`, `err_count`;
  - sets `lat_min` to all-ones;
  - does not change FSM state.
  - If coincident with the UPDATE edge, the clear wins: the sample is discarded from all statistics. `lat_valid`/`lat_err`/`lat_alarm`/`ts_clear` still pulse.
- Zero delta (`ts_rx`==`ts_tx`) is a good sample of 0.
- Reset (`rst_n`=0 at an edge): FSM → IDLE; all pulse outputs 0; all statistics as after `stats_clear`.
  - Reset mid-operation abandons the pending sample. No `ts_clear` is issued; the latch is cleared by its own reset.

## Timing
- All outputs are registered.
- `ts_valid` first sampled high at edge E0 → `diff` registered at E0.
- At E1, the statistics and the pulse outputs update. They are visible in the cycle after E1, i.e. a latency of 2 cycles from `ts_valid` high.
- `ts_clear` is high for exactly one cycle, concurrent with `lat_valid`/`lat_err`.
- The latch drops `ts_valid` at the edge that samples `ts_clear`.
- HOLD absorbs one cycle of slack. The earliest next acceptance is 4 cycles after E0.
- `lat_valid`, `lat_err`, `lat_alarm` and `ts_clear` are never high for two consecutive cycles.
- Statistics are stable between UPDATE edges; readout may sample them at any cycle.

## Test plan
- After reset: `lat_min`=0xFFFFFFFF, all other stats 0, no pulses. `ts_tx`=100, `ts_rx`=350, `ts_valid` held high for 10 cycles → exactly one `lat_valid` and one `ts_clear`, 2 cycles after `ts_valid` rises; `lat_last`=`lat_min`=`lat_max`=250, `lat_sum`=250, `lat_count`=1.
- Three samples of 40, 10 and 70 → min 10, max 70, sum 120, count 3. With `alarm_thresh`=40, `lat_alarm` fires only for 70; a sample exactly equal to 40 raises no alarm.
- `ts_tx`=500, `ts_rx`=400 → `lat_err` pulse, `err_count`=1, `lat_valid` low, other statistics unchanged, `ts_clear` still pulses.
- `ts_tx`=0, `ts_rx`=2^33 with `DELTA_W`=32 → sample 0xFFFFFFFF. With `SUM_W`=33 and `lat_sum` preloaded by prior samples, `lat_sum` clamps at all-ones.
- `stats_clear` asserted on the UPDATE edge of a 250 sample → stats equal their cleared values afterwards, `lat_valid` and `ts_clear` still pulse.
- `rst_n` low during UPDATE → no `ts_clear` pulse; stats cleared; FSM in IDLE. A next pair (10→30) yields `lat_last`=20, `lat_count`=1.
